// File: rtl/id_ex_pipeline_reg.sv
// id_ex_pipeline_reg: ID/EX pipeline register with stall, flush and write-back bypass.
// Optional performance counters are enabled by defining ID_EX_PERF_CNT_EN.
module id_ex_pipeline_reg #(
    parameter int CTRL_W     = 11,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  Stall,
    input  logic                  Flush,
    input  logic                  IdValid,
    input  logic [31:0]           IdPCPlus4,
    input  logic [31:0]           IdReadData1,
    input  logic [31:0]           IdReadData2,
    input  logic [31:0]           IdImmExt,
    input  logic [REG_ADDR_W-1:0] IdRs,
    input  logic [REG_ADDR_W-1:0] IdRt,
    input  logic [REG_ADDR_W-1:0] IdRd,
    input  logic [REG_ADDR_W-1:0] IdShamt,
    input  logic [CTRL_W-1:0]     IdCtrl,
    input  logic                  WbRegWrite,
    input  logic [REG_ADDR_W-1:0] WbWriteReg,
    input  logic [31:0]           WbWriteData,
    output logic                  ExValid,
    output logic [31:0]           ExPCPlus4,
    output logic [31:0]           ExReadData1,
    output logic [31:0]           ExReadData2,
    output logic [31:0]           ExImmExt,
    output logic [REG_ADDR_W-1:0] ExRs,
    output logic [REG_ADDR_W-1:0] ExRt,
    output logic [REG_ADDR_W-1:0] ExRd,
    output logic [REG_ADDR_W-1:0] ExShamt,
    output logic [CTRL_W-1:0]     ExCtrl,
    output logic [31:0]           StallCount,
    output logic [31:0]           BubbleCount
);
    logic wb_ok, byp1, byp2, ref1, ref2, bubble, clear;

    // Register $0 is hardwired zero, so a WB write to it never forwards.
    assign wb_ok  = WbRegWrite && (WbWriteReg != '0);
    assign byp1   = wb_ok && (WbWriteReg == IdRs);
    assign byp2   = wb_ok && (WbWriteReg == IdRt);
    assign ref1   = ExValid && wb_ok && (WbWriteReg == ExRs);
    assign ref2   = ExValid && wb_ok && (WbWriteReg == ExRt);
    assign bubble = Flush || (!Stall && !IdValid);
    assign clear  = !Rst || bubble;

    always_ff @(posedge Clk) begin
        if (clear) begin
            ExValid     <= 1'b0;
            ExPCPlus4   <= '0;
            ExReadData1 <= '0;
            ExReadData2 <= '0;
            ExImmExt    <= '0;
            ExRs        <= '0;
            ExRt        <= '0;
            ExRd        <= '0;
            ExShamt     <= '0;
            ExCtrl      <= '0;
        end else if (Stall) begin
            if (ref1) ExReadData1 <= WbWriteData;
            if (ref2) ExReadData2 <= WbWriteData;
        end else begin
            ExValid     <= 1'b1;
            ExPCPlus4   <= IdPCPlus4;
            ExReadData1 <= byp1 ? WbWriteData : IdReadData1;
            ExReadData2 <= byp2 ? WbWriteData : IdReadData2;
            ExImmExt    <= IdImmExt;
            ExRs        <= IdRs;
            ExRt        <= IdRt;
            ExRd        <= IdRd;
            ExShamt     <= IdShamt;
            ExCtrl      <= IdCtrl;
        end
    end

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] stall_cnt, bubble_cnt;

    // Saturating counters: they stick at all-ones instead of wrapping.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (Stall && !Flush && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
            if (bubble && bubble_cnt != '1) bubble_cnt <= bubble_cnt + 32'd1;
        end
    end

    assign StallCount  = stall_cnt;
    assign BubbleCount = bubble_cnt;
`else
    assign StallCount  = '0;
    assign BubbleCount = '0;
`endif
endmodule
